// File: rtl/pipelined_addsub_pkg.sv
// Shared types for the pipelined add/subtract unit: operation encoding, NZCV flag bundle
// and the operand-preparation rules applied when an operation is accepted.
package pipelined_addsub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        ADC = 2'd2,
        SBC = 2'd3
    } addsub_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    function automatic logic invertsB(addsub_op_t op);
        return (op == SUB) || (op == SBC);
    endfunction

    // Subtraction is a + ~b + 1; the carry-using forms take the incoming carry flag instead.
    function automatic logic opCarryIn(addsub_op_t op, logic flagC);
        logic cin;
        case (op)
            ADD:     cin = 1'b0;
            SUB:     cin = 1'b1;
            default: cin = flagC;
        endcase
        return cin;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle of the add/subtract unit; the unit sits on the slave side.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    import pipelined_addsub_pkg::*;

    logic             in_valid;
    logic             in_ready;
    addsub_op_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, op, a, b, c_in, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );

    modport slave (
        input  in_valid, op, a, b, c_in, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );

endinterface

// File: rtl/pipelined_addsub_slice.sv
// Combinational S-bit slice of the carry chain in generate/propagate lookahead form; also
// reports the carry into its top bit (for overflow) and whether its sum is all zeros.
module addsub_slice #(
    parameter int S = 8
) (
    input  logic [S-1:0] a_i,
    input  logic [S-1:0] b_i,
    input  logic         cin_i,
    output logic [S-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o,
    output logic         zero_o
);

    logic [S-1:0] prop;
    logic [S-1:0] gen;
    logic [S:0]   carry;
    logic         grpG;
    logic         grpP;

    // Each carry is the group generate of bits [i:0] plus the group propagate of the incoming carry.
    always_comb begin
        prop     = a_i ^ b_i;
        gen      = a_i & b_i;
        grpG     = 1'b0;
        grpP     = 1'b1;
        carry    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < S; i++) begin
            grpG       = gen[i] | (prop[i] & grpG);
            grpP       = grpP & prop[i];
            carry[i+1] = grpG | (grpP & cin_i);
        end
    end

    assign sum_o  = prop ^ carry[S-1:0];
    assign cout_o = carry[S];
    assign cmsb_o = carry[S-1];
    assign zero_o = ~|sum_o;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract with NZCV flags: one carry-chain slice per stage, one global
// stall enable, operands shrinking and the result growing as they move down the pipe.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic               clk,
    input logic               rst_n,
    pipelined_addsub_if.slave bus
);

    localparam int S = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_depth
        $error("pipelined_addsub: STAGES must be in 1..WIDTH");
    end else if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
    end

    logic             en;
    logic             outValid;
    logic [WIDTH-1:0] bPrep;
    logic             cinPrep;
    nzcv_t            flags;

    assign bPrep        = invertsB(bus.op) ? ~bus.b : bus.b;
    assign cinPrep      = opCarryIn(bus.op, bus.c_in);
    assign en           = ~outValid | bus.out_ready;
    assign bus.in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM  = WIDTH - k * S;
        localparam int DONE = (k + 1) * S;

        logic [REM-1:0]  aIn;
        logic [REM-1:0]  bIn;
        logic            cIn;
        logic            zeroIn;
        logic            validIn;
        logic [S-1:0]    sliceSum;
        logic            sliceCout;
        logic            sliceCmsb;
        logic            sliceZero;
        logic [DONE-1:0] res_d;
        logic [DONE-1:0] res_q;
        logic            carry_q;
        logic            zero_q;
        logic            valid_q;

        if (k == 0) begin : g_first
            assign aIn     = bus.a;
            assign bIn     = bPrep;
            assign cIn     = cinPrep;
            assign zeroIn  = 1'b1;
            assign validIn = bus.in_valid;
            assign res_d   = sliceSum;
        end else begin : g_next
            assign aIn     = g_stage[k-1].g_fwd.a_q;
            assign bIn     = g_stage[k-1].g_fwd.b_q;
            assign cIn     = g_stage[k-1].carry_q;
            assign zeroIn  = g_stage[k-1].zero_q;
            assign validIn = g_stage[k-1].valid_q;
            assign res_d   = {sliceSum, g_stage[k-1].res_q};
        end

        addsub_slice #(.S(S)) u_slice (
            .a_i   (aIn[S-1:0]),
            .b_i   (bIn[S-1:0]),
            .cin_i (cIn),
            .sum_o (sliceSum),
            .cout_o(sliceCout),
            .cmsb_o(sliceCmsb),
            .zero_o(sliceZero)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                zero_q  <= 1'b0;
                res_q   <= '0;
            end else if (en) begin
                valid_q <= validIn;
                carry_q <= sliceCout;
                zero_q  <= zeroIn & sliceZero;
                res_q   <= res_d;
            end
        end

        // Only the final slice holds the MSB, so only it produces the overflow flag.
        if (k < STAGES - 1) begin : g_fwd
            logic [REM-S-1:0] a_q;
            logic [REM-S-1:0] b_q;
            logic             unusedCmsb;

            assign unusedCmsb = sliceCmsb;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= aIn[REM-1:S];
                    b_q <= bIn[REM-1:S];
                end
            end
        end else begin : g_last
            logic v_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                end else if (en) begin
                    v_q <= sliceCmsb ^ sliceCout;
                end
            end
        end
    end

    assign outValid = g_stage[STAGES-1].valid_q;
    assign flags    = {g_stage[STAGES-1].res_q[WIDTH-1],
                       g_stage[STAGES-1].zero_q,
                       g_stage[STAGES-1].carry_q,
                       g_stage[STAGES-1].g_last.v_q};

    assign bus.out_valid = outValid;
    assign bus.result    = g_stage[STAGES-1].res_q;
    assign bus.flag_n    = flags.n;
    assign bus.flag_z    = flags.z;
    assign bus.flag_c    = flags.c;
    assign bus.flag_v    = flags.v;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three configurations driven in lockstep, each checked by a
// plain-arithmetic reference model through its own scoreboard, plus directed corner sequences.
`timescale 1ns/1ps
module tb_pipelined_addsub;
    import pipelined_addsub_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  nzcv;
    } expect_t;

    typedef struct {
        addsub_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] res;
        logic [3:0]  nzcv;
    } vector_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic        outReady;
    logic        cIn;
    addsub_op_t  op;
    logic [63:0] aVal;
    logic [63:0] bVal;

    int compared   = 0;
    int mismatched = 0;

    expect_t q32[$];
    expect_t q16[$];
    expect_t q64[$];

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(32)) if32 ();
    pipelined_addsub_if #(.WIDTH(16)) if16 ();
    pipelined_addsub_if #(.WIDTH(64)) if64 ();

    assign if32.in_valid = inValid;
    assign if32.op = op;
    assign if32.a = aVal[31:0];
    assign if32.b = bVal[31:0];
    assign if32.c_in = cIn;
    assign if32.out_ready = outReady;
    assign if16.in_valid = inValid;
    assign if16.op = op;
    assign if16.a = aVal[15:0];
    assign if16.b = bVal[15:0];
    assign if16.c_in = cIn;
    assign if16.out_ready = outReady;
    assign if64.in_valid = inValid;
    assign if64.op = op;
    assign if64.a = aVal;
    assign if64.b = bVal;
    assign if64.c_in = cIn;
    assign if64.out_ready = outReady;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    pipelined_addsub #(.WIDTH(16), .STAGES(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    pipelined_addsub #(.WIDTH(64), .STAGES(8)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));

    // Whole-word arithmetic: extend to w+1 bits, add, read carry and overflow from operand signs.
    function automatic expect_t model(int w, addsub_op_t o, logic [63:0] x, logic [63:0] y, logic ci);
        expect_t     e;
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] xm;
        logic [63:0] ym;
        logic        c0;
        mask = (65'd1 << w) - 65'd1;
        xm   = x & mask[63:0];
        ym   = (o == SUB || o == SBC) ? (~y & mask[63:0]) : (y & mask[63:0]);
        c0   = (o == ADD) ? 1'b0 : (o == SUB) ? 1'b1 : ci;
        full = {1'b0, xm} + {1'b0, ym} + {64'd0, c0};
        e.res     = full[63:0] & mask[63:0];
        e.nzcv[3] = e.res[w-1];
        e.nzcv[2] = (e.res == 64'd0);
        e.nzcv[1] = full[w];
        e.nzcv[0] = (xm[w-1] == ym[w-1]) && (e.res[w-1] != xm[w-1]);
        return e;
    endfunction

    task automatic checkValue(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(string name, expect_t e, logic [63:0] r, logic [3:0] f);
        compared++;
        if (r !== e.res || f !== e.nzcv) begin
            mismatched++;
            $display("[TB] FAIL %s: got res=%h nzcv=%b, want res=%h nzcv=%b", name, r, f, e.res, e.nzcv);
        end
    endtask

    task automatic spurious(string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got an output transfer, want none (scoreboard empty)", name);
    endtask

    task automatic applyStimulus(addsub_op_t o, logic [63:0] x, logic [63:0] y, logic ci);
        op      = o;
        aVal    = x;
        bVal    = y;
        cIn     = ci;
        inValid = 1'b1;
    endtask

    // Scoreboards: push the modelled result on each accept, compare on each output transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (if32.in_valid && if32.in_ready)
                q32.push_back(model(32, if32.op, 64'(if32.a), 64'(if32.b), if32.c_in));
            if (if32.out_valid && if32.out_ready) begin
                if (q32.size() == 0) spurious("dut32 stream");
                else checkOutput("dut32 stream", q32.pop_front(), 64'(if32.result),
                                 {if32.flag_n, if32.flag_z, if32.flag_c, if32.flag_v});
            end
            if (if16.in_valid && if16.in_ready)
                q16.push_back(model(16, if16.op, 64'(if16.a), 64'(if16.b), if16.c_in));
            if (if16.out_valid && if16.out_ready) begin
                if (q16.size() == 0) spurious("dut16 stream");
                else checkOutput("dut16 stream", q16.pop_front(), 64'(if16.result),
                                 {if16.flag_n, if16.flag_z, if16.flag_c, if16.flag_v});
            end
            if (if64.in_valid && if64.in_ready)
                q64.push_back(model(64, if64.op, if64.a, if64.b, if64.c_in));
            if (if64.out_valid && if64.out_ready) begin
                if (q64.size() == 0) spurious("dut64 stream");
                else checkOutput("dut64 stream", q64.pop_front(), if64.result,
                                 {if64.flag_n, if64.flag_z, if64.flag_c, if64.flag_v});
            end
        end
    end

    initial begin
        vector_t     vecs[10];
        int          lat32, lat16, lat64;
        logic [31:0] got32;
        logic [3:0]  gotF32;
        int          firstStep, lastStep, count, accepted, drained, seen;
        logic [31:0] snapRes;
        logic [3:0]  snapFlags;

        vecs[0] = '{ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1001};
        vecs[1] = '{SUB, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b0110};
        vecs[2] = '{SUB, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 4'b1000};
        vecs[3] = '{ADC, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0110};
        vecs[4] = '{SBC, 32'h00000010, 32'h00000001, 1'b0, 32'h0000000E, 4'b0010};
        vecs[5] = '{ADD, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0111};
        vecs[6] = '{SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 4'b0011};
        vecs[7] = '{ADC, 32'h0000FFFF, 32'h00000001, 1'b1, 32'h00010001, 4'b0000};
        vecs[8] = '{ADD, 32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 4'b0000};
        vecs[9] = '{SBC, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0110};

        rst_n = 1'b0; inValid = 1'b0; outReady = 1'b1;
        op = ADD; aVal = '0; bVal = '0; cIn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        checkValue("reset out_valid32", 64'(if32.out_valid), 64'd0);
        checkValue("reset result32", 64'(if32.result), 64'd0);
        checkValue("reset flags32", 64'({if32.flag_n, if32.flag_z, if32.flag_c, if32.flag_v}), 64'd0);
        checkValue("reset in_ready32", 64'(if32.in_ready), 64'd1);
        checkValue("reset out_valid16/64", 64'({if16.out_valid, if64.out_valid}), 64'd0);
        @(posedge clk); #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].cin);
            lat32 = -1; lat16 = -1; lat64 = -1; got32 = '0; gotF32 = '0;
            for (int n = 1; n <= 12; n++) begin
                @(posedge clk); #1;
                if (n == 1) inValid = 1'b0;
                if (if32.out_valid && lat32 < 0) begin
                    lat32  = n;
                    got32  = if32.result;
                    gotF32 = {if32.flag_n, if32.flag_z, if32.flag_c, if32.flag_v};
                end
                if (if16.out_valid && lat16 < 0) lat16 = n;
                if (if64.out_valid && lat64 < 0) lat64 = n;
            end
            checkValue($sformatf("vec%0d latency32", i), 64'(lat32), 64'd4);
            checkValue($sformatf("vec%0d latency16", i), 64'(lat16), 64'd1);
            checkValue($sformatf("vec%0d latency64", i), 64'(lat64), 64'd8);
            checkValue($sformatf("vec%0d result32", i), 64'(got32), 64'(vecs[i].res));
            checkValue($sformatf("vec%0d nzcv32", i), 64'(gotF32), 64'(vecs[i].nzcv));
        end

        $display("[TB] back-to-back");
        firstStep = -1; lastStep = -1; count = 0;
        for (int n = 1; n <= 16; n++) begin
            if (n <= 8) applyStimulus(ADD, 64'(n - 1), 64'(32'h100 * (n - 1)), 1'b0);
            else inValid = 1'b0;
            @(posedge clk); #1;
            if (if32.out_valid) begin
                if (firstStep < 0) firstStep = n;
                lastStep = n;
                checkValue($sformatf("b2b result%0d", count), 64'(if32.result), 64'(32'h101 * count));
                count++;
            end
        end
        checkValue("b2b first step", 64'(firstStep), 64'd4);
        checkValue("b2b count", 64'(count), 64'd8);
        checkValue("b2b last step", 64'(lastStep), 64'd11);

        $display("[TB] backpressure");
        outReady = 1'b0; accepted = 0;
        for (int j = 0; j < 6; j++) begin
            applyStimulus(SUB, 64'(1000 * (j + 1)), 64'(j + 3), 1'b0);
            @(negedge clk);
            if (if32.in_valid && if32.in_ready) accepted++;
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        checkValue("stall accepted32", 64'(accepted), 64'd4);
        snapRes   = if32.result;
        snapFlags = {if32.flag_n, if32.flag_z, if32.flag_c, if32.flag_v};
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checkValue("stall in_ready32", 64'(if32.in_ready), 64'd0);
            checkValue("stall out_valid32", 64'(if32.out_valid), 64'd1);
            checkValue("stall result32", 64'(if32.result), 64'(snapRes));
            checkValue("stall flags32", 64'({if32.flag_n, if32.flag_z, if32.flag_c, if32.flag_v}), 64'(snapFlags));
        end
        outReady = 1'b1; drained = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (if32.out_valid && if32.out_ready) drained++;
            @(posedge clk); #1;
        end
        checkValue("drain count32", 64'(drained), 64'd4);
        checkValue("drain leftover32", 64'(q32.size()), 64'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(ADD, 64'h1234, 64'h1111, 1'b0);
        @(posedge clk); #1;
        applyStimulus(SUB, 64'h9999, 64'h0001, 1'b0);
        @(posedge clk); #1;
        inValid = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q32.delete(); q16.delete(); q64.delete();
        checkValue("midreset result32", 64'(if32.result), 64'd0);
        checkValue("midreset flags32", 64'({if32.flag_n, if32.flag_z, if32.flag_c, if32.flag_v}), 64'd0);
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            if (if32.out_valid || if16.out_valid || if64.out_valid) seen++;
            @(posedge clk); #1;
        end
        checkValue("midreset stale outputs", 64'(seen), 64'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            inValid  = ($urandom_range(0, 3) != 0);
            op       = addsub_op_t'(2'($urandom_range(0, 3)));
            aVal     = {$urandom(), $urandom()};
            bVal     = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) bVal = aVal;
            cIn      = 1'($urandom_range(0, 1));
            outReady = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkValue("final leftover32", 64'(q32.size()), 64'd0);
        checkValue("final leftover16", 64'(q16.size()), 64'd0);
        checkValue("final leftover64", 64'(q64.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
